// File: rtl/te_state_transfer.sv
// Copies per-channel state blocks between the 32-entry channel state memory and the four
// physical correlator buffers, one word per cycle. Define TE_PARTIAL_SAVE_EN to write back only SAVE_WORDS words per slot.
module te_state_transfer #(
    parameter int STATE_WORDS = 8,
    parameter int WORD_AW     = 3,
    parameter int DATA_W      = 32,
    parameter int SAVE_WORDS  = 4
) (
    input  logic                 clk,
    input  logic                 rst_b,
    input  logic                 start_load,
    input  logic                 start_save,
    input  logic [3:0]           physical_channel_en,
    input  logic [4:0]           logic_channel_index0,
    input  logic [4:0]           logic_channel_index1,
    input  logic [4:0]           logic_channel_index2,
    input  logic [4:0]           logic_channel_index3,
    output logic                 busy,
    output logic                 load_done,
    output logic                 save_done,
    output logic [5+WORD_AW-1:0] state_mem_addr,
    output logic                 state_mem_rd,
    output logic                 state_mem_wr,
    output logic [DATA_W-1:0]    state_mem_wdata,
    input  logic [DATA_W-1:0]    state_mem_rdata,
    output logic [WORD_AW-1:0]   phy_state_addr,
    output logic [3:0]           phy_state_we,
    output logic [3:0]           phy_state_rd,
    output logic [DATA_W-1:0]    phy_state_wdata,
    input  logic [DATA_W-1:0]    phy_state_rdata0,
    input  logic [DATA_W-1:0]    phy_state_rdata1,
    input  logic [DATA_W-1:0]    phy_state_rdata2,
    input  logic [DATA_W-1:0]    phy_state_rdata3
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_SAVE, S_FLUSH, S_DONE} state_t;

    localparam logic [WORD_AW-1:0] LOAD_LAST = WORD_AW'(STATE_WORDS - 1);
`ifdef TE_PARTIAL_SAVE_EN
    localparam logic [WORD_AW-1:0] SAVE_LAST = WORD_AW'(SAVE_WORDS - 1);
`else
    localparam logic [WORD_AW-1:0] SAVE_LAST = LOAD_LAST;
`endif

    if ((1 << WORD_AW) != STATE_WORDS || STATE_WORDS < 2 || STATE_WORDS > 16) begin : g_bad_words
        $error("STATE_WORDS must be a power of two in 2..16 and equal 2**WORD_AW");
    end
    if (SAVE_WORDS < 1 || SAVE_WORDS > STATE_WORDS) begin : g_bad_save_words
        $error("SAVE_WORDS must lie in 1..STATE_WORDS");
    end

    state_t               state_q;
    logic                 save_q;
    logic [3:0]           pend_q;
    logic [3:0][4:0]      idx_q;
    logic [1:0]           slot_q;
    logic [1:0]           wr_slot_q;
    logic [WORD_AW-1:0]   word_q;
    logic                 busy_q, load_done_q, save_done_q;
    logic [5+WORD_AW-1:0] mem_addr_q;
    logic                 mem_rd_q, mem_wr_q;
    logic [WORD_AW-1:0]   phy_addr_q;
    logic [3:0]           phy_we_q, phy_rd_q;

    logic [3:0][4:0]        idx_in;
    logic [3:0][DATA_W-1:0] phy_rdata;
    logic                   start;

    assign idx_in    = {logic_channel_index3, logic_channel_index2, logic_channel_index1, logic_channel_index0};
    assign phy_rdata = {phy_state_rdata3, phy_state_rdata2, phy_state_rdata1, phy_state_rdata0};
    assign start     = start_load | start_save;

    function automatic logic [1:0] first_slot(input logic [3:0] m);
        logic [1:0] f;
        f = 2'd0;
        for (int i = 3; i >= 0; i--) begin
            if (m[i]) f = 2'(i);
        end
        return f;
    endfunction

    // Next read to issue: first word of the lowest pending slot, or the next word of the current one.
    logic               rd_go, rd_save;
    logic [1:0]         rd_slot;
    logic [WORD_AW-1:0] rd_word, last_word;
    logic [3:0]         pend_d;
    logic [4:0]         rd_idx;

    always_comb begin
        rd_go     = 1'b0;
        rd_save   = save_q;
        rd_slot   = slot_q;
        rd_word   = '0;
        pend_d    = pend_q;
        last_word = save_q ? SAVE_LAST : LOAD_LAST;
        case (state_q)
            S_IDLE: begin
                if (start && (|physical_channel_en)) begin
                    rd_go   = 1'b1;
                    rd_save = ~start_load;
                    rd_slot = first_slot(physical_channel_en);
                    pend_d  = physical_channel_en & ~(4'b0001 << rd_slot);
                end
            end
            S_LOAD, S_SAVE: begin
                if (word_q != last_word) begin
                    rd_go   = 1'b1;
                    rd_word = word_q + 1'b1;
                end else if (|pend_q) begin
                    rd_go   = 1'b1;
                    rd_slot = first_slot(pend_q);
                    pend_d  = pend_q & ~(4'b0001 << rd_slot);
                end
            end
            default: ;
        endcase
        rd_idx = (state_q == S_IDLE) ? idx_in[rd_slot] : idx_q[rd_slot];
    end

    always_ff @(posedge clk or negedge rst_b) begin
        if (!rst_b) begin
            state_q     <= S_IDLE;
            save_q      <= 1'b0;
            pend_q      <= '0;
            idx_q       <= '0;
            slot_q      <= '0;
            wr_slot_q   <= '0;
            word_q      <= '0;
            busy_q      <= 1'b0;
            load_done_q <= 1'b0;
            save_done_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            phy_addr_q  <= '0;
            phy_we_q    <= '0;
            phy_rd_q    <= '0;
        end else begin
            mem_rd_q    <= 1'b0;
            mem_wr_q    <= 1'b0;
            phy_we_q    <= '0;
            phy_rd_q    <= '0;
            load_done_q <= 1'b0;
            save_done_q <= 1'b0;

            // The read presented this cycle becomes next cycle's write on the other memory.
            if (state_q == S_LOAD || state_q == S_SAVE) begin
                wr_slot_q <= slot_q;
                if (save_q) begin
                    mem_wr_q   <= 1'b1;
                    mem_addr_q <= {idx_q[slot_q], word_q};
                end else begin
                    phy_we_q   <= 4'b0001 << slot_q;
                    phy_addr_q <= word_q;
                end
            end

            if (rd_go) begin
                slot_q <= rd_slot;
                word_q <= rd_word;
                pend_q <= pend_d;
                if (rd_save) begin
                    phy_rd_q   <= 4'b0001 << rd_slot;
                    phy_addr_q <= rd_word;
                end else begin
                    mem_rd_q   <= 1'b1;
                    mem_addr_q <= {rd_idx, rd_word};
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        save_q  <= ~start_load;
                        idx_q   <= idx_in;
                        busy_q  <= 1'b1;
                        if (|physical_channel_en) state_q <= start_load ? S_LOAD : S_SAVE;
                        else                      state_q <= S_FLUSH;
                    end
                end
                S_LOAD, S_SAVE: begin
                    if (!rd_go) state_q <= S_FLUSH;
                end
                S_FLUSH: begin
                    state_q     <= S_DONE;
                    load_done_q <= ~save_q;
                    save_done_q <= save_q;
                end
                S_DONE: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign busy            = busy_q;
    assign load_done       = load_done_q;
    assign save_done       = save_done_q;
    assign state_mem_addr  = mem_addr_q;
    assign state_mem_rd    = mem_rd_q;
    assign state_mem_wr    = mem_wr_q;
    assign phy_state_addr  = phy_addr_q;
    assign phy_state_we    = phy_we_q;
    assign phy_state_rd    = phy_rd_q;
    assign state_mem_wdata = mem_wr_q ? phy_rdata[wr_slot_q] : '0;
    assign phy_state_wdata = (|phy_we_q) ? state_mem_rdata : '0;

endmodule

// File: tb/tb_te_state_transfer.sv
// Scoreboard bench for te_state_transfer: directed sequences push expected strobes, a negedge monitor checks them.
`timescale 1ns/1ps
module tb_te_state_transfer;
    localparam int STATE_WORDS = 8;
    localparam int WORD_AW     = 3;
    localparam int DATA_W      = 32;
    localparam int SAVE_WORDS  = 4;
`ifdef TE_PARTIAL_SAVE_EN
    localparam int SW = SAVE_WORDS;
`else
    localparam int SW = STATE_WORDS;
`endif
    localparam int K_MEMRD = 0, K_PHYRD = 1, K_MEMWR = 2, K_PHYWE = 3, K_LDONE = 4, K_SDONE = 5;

    typedef struct {
        int          kind;
        int          addr;
        int          sel;
        logic [31:0] data;
        int          cyc;
    } ev_t;

    ev_t exp_q[$];
    int  total = 0;
    int  bad   = 0;
    int  cyc   = 0;

    logic                 clk = 1'b0;
    logic                 rst_b;
    logic                 start_load, start_save;
    logic [3:0]           physical_channel_en;
    logic [4:0]           logic_channel_index0, logic_channel_index1, logic_channel_index2, logic_channel_index3;
    logic                 busy, load_done, save_done;
    logic [5+WORD_AW-1:0] state_mem_addr;
    logic                 state_mem_rd, state_mem_wr;
    logic [DATA_W-1:0]    state_mem_wdata;
    logic [DATA_W-1:0]    state_mem_rdata = '0;
    logic [WORD_AW-1:0]   phy_state_addr;
    logic [3:0]           phy_state_we, phy_state_rd;
    logic [DATA_W-1:0]    phy_state_wdata;
    logic [DATA_W-1:0]    phy_rdata [4];

    te_state_transfer #(
        .STATE_WORDS(STATE_WORDS), .WORD_AW(WORD_AW), .DATA_W(DATA_W), .SAVE_WORDS(SAVE_WORDS)
    ) dut (
        .clk(clk), .rst_b(rst_b),
        .start_load(start_load), .start_save(start_save),
        .physical_channel_en(physical_channel_en),
        .logic_channel_index0(logic_channel_index0), .logic_channel_index1(logic_channel_index1),
        .logic_channel_index2(logic_channel_index2), .logic_channel_index3(logic_channel_index3),
        .busy(busy), .load_done(load_done), .save_done(save_done),
        .state_mem_addr(state_mem_addr), .state_mem_rd(state_mem_rd), .state_mem_wr(state_mem_wr),
        .state_mem_wdata(state_mem_wdata), .state_mem_rdata(state_mem_rdata),
        .phy_state_addr(phy_state_addr), .phy_state_we(phy_state_we), .phy_state_rd(phy_state_rd),
        .phy_state_wdata(phy_state_wdata),
        .phy_state_rdata0(phy_rdata[0]), .phy_state_rdata1(phy_rdata[1]),
        .phy_state_rdata2(phy_rdata[2]), .phy_state_rdata3(phy_rdata[3])
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory models with 1-cycle read latency; stale cycles return a marker so mistimed writes show up.
    initial for (int s = 0; s < 4; s++) phy_rdata[s] = '0;
    always @(posedge clk) begin
        state_mem_rdata <= state_mem_rd ? (32'hA000_0000 | 32'(state_mem_addr)) : 32'hDEAD_0000;
        for (int s = 0; s < 4; s++)
            phy_rdata[s] <= phy_state_rd[s] ? (32'hB000_0000 | 32'(s << 8) | 32'(phy_state_addr)) : 32'hDEAD_0001;
    end

    task automatic push_ev(input int kind, input int addr, input int sel, input logic [31:0] data, input int c);
        ev_t e;
        e.kind = kind; e.addr = addr; e.sel = sel; e.data = data; e.cyc = c;
        exp_q.push_back(e);
    endtask

    task automatic check_ev(input int kind, input int addr, input int sel, input logic [31:0] data);
        ev_t e;
        total++;
        if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL unexpected_event cyc=%0d got kind=%0d addr=%h sel=%h data=%h, expected none", cyc, kind, addr, sel, data);
            return;
        end
        e = exp_q.pop_front();
        if (e.kind != kind || e.addr != addr || e.sel != sel || e.data != data || e.cyc != cyc) begin
            bad++;
            $display("FAIL event got kind=%0d addr=%h sel=%h data=%h cyc=%0d, expected kind=%0d addr=%h sel=%h data=%h cyc=%0d",
                     kind, addr, sel, data, cyc, e.kind, e.addr, e.sel, e.data, e.cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_b) begin
            if (state_mem_rd)   check_ev(K_MEMRD, int'(state_mem_addr), 0, 32'h0);
            if (|phy_state_rd)  check_ev(K_PHYRD, int'(phy_state_addr), int'(phy_state_rd), 32'h0);
            if (state_mem_wr)   check_ev(K_MEMWR, int'(state_mem_addr), 0, state_mem_wdata);
            if (|phy_state_we)  check_ev(K_PHYWE, int'(phy_state_addr), int'(phy_state_we), phy_state_wdata);
            if (load_done)      check_ev(K_LDONE, 0, 0, 32'h0);
            if (save_done)      check_ev(K_SDONE, 0, 0, 32'h0);
        end
    end

    // Expected strobes for a sequence started in cycle c0; events at or after cycle 'cut' are not expected.
    task automatic gen(input bit save, input logic [3:0] en, input int i0, input int i1, input int i2, input int i3,
                       input int c0, input int cut);
        int idx[4];
        int sl[$];
        int wd[$];
        int k, n, j;
        idx[0] = i0; idx[1] = i1; idx[2] = i2; idx[3] = i3;
        n = save ? SW : STATE_WORDS;
        for (int s = 0; s < 4; s++)
            if (en[s]) for (int w = 0; w < n; w++) begin sl.push_back(s); wd.push_back(w); end
        k = sl.size();
        for (int t = 1; t <= k + 2; t++) begin
            if (c0 + t >= cut) break;
            if (t <= k) begin
                j = t - 1;
                if (save) push_ev(K_PHYRD, wd[j], 1 << sl[j], 32'h0, c0 + t);
                else      push_ev(K_MEMRD, idx[sl[j]] * STATE_WORDS + wd[j], 0, 32'h0, c0 + t);
            end
            if (t >= 2 && t <= k + 1) begin
                j = t - 2;
                if (save) push_ev(K_MEMWR, idx[sl[j]] * STATE_WORDS + wd[j], 0,
                                  32'hB000_0000 | 32'(sl[j] << 8) | 32'(wd[j]), c0 + t);
                else      push_ev(K_PHYWE, wd[j], 1 << sl[j],
                                  32'hA000_0000 | 32'(idx[sl[j]] * STATE_WORDS + wd[j]), c0 + t);
            end
            if (t == k + 2) push_ev(save ? K_SDONE : K_LDONE, 0, 0, 32'h0, c0 + t);
        end
    endtask

    task automatic check_drained(input string name);
        total++;
        if (exp_q.size() != 0) begin
            bad++;
            $display("FAIL %s missing events: %0d still expected, required 0", name, exp_q.size());
            exp_q.delete();
        end
    endtask

    task automatic check_all_zero(input string name);
        logic [127:0] v;
        v = {busy, load_done, save_done, state_mem_addr, state_mem_rd, state_mem_wr, state_mem_wdata,
             phy_state_addr, phy_state_we, phy_state_rd, phy_state_wdata};
        total++;
        if (v != '0) begin
            bad++;
            $display("FAIL %s outputs=%h required 0", name, v);
        end
    endtask

    task automatic set_inputs(input logic [3:0] en, input int i0, input int i1, input int i2, input int i3);
        physical_channel_en  = en;
        logic_channel_index0 = 5'(i0);
        logic_channel_index1 = 5'(i1);
        logic_channel_index2 = 5'(i2);
        logic_channel_index3 = 5'(i3);
    endtask

    task automatic run_seq(input string name, input bit sl, input bit ss, input logic [3:0] en,
                           input int i0, input int i1, input int i2, input int i3, input bit mid_save);
        int c0, k;
        @(posedge clk); #1;
        c0 = cyc;
        start_load = sl;
        start_save = ss;
        set_inputs(en, i0, i1, i2, i3);
        gen(!sl, en, i0, i1, i2, i3, c0, 1 << 30);
        k = $countones(en) * (sl ? STATE_WORDS : SW);
        @(posedge clk); #1;
        start_load = 1'b0;
        set_inputs(~en, i0 ^ 21, i1 ^ 21, i2 ^ 21, i3 ^ 21);
        for (int t = 1; t <= k + 3; t++) begin
            start_save = mid_save && (t == 3);
            total++;
            if (busy !== (t <= k + 2)) begin
                bad++;
                $display("FAIL %s busy at cycle %0d: got %b required %b", name, t, busy, (t <= k + 2));
            end
            @(posedge clk); #1;
        end
        start_save = 1'b0;
        check_drained(name);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int c0;
        rst_b = 1'b0;
        start_load = 1'b0;
        start_save = 1'b0;
        set_inputs(4'h0, 0, 0, 0, 0);
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset_state");
        rst_b = 1'b1;

        run_seq("load_all",      1'b1, 1'b0, 4'b1111, 3, 7, 16, 31, 1'b0);
        run_seq("load_none",     1'b1, 1'b0, 4'b0000, 1, 2, 3, 4, 1'b0);
        run_seq("save_sparse",   1'b0, 1'b1, 4'b1010, 1, 2, 5, 9, 1'b0);
        run_seq("both_starts",   1'b1, 1'b1, 4'b0110, 11, 12, 13, 14, 1'b1);
        run_seq("load_single",   1'b1, 1'b0, 4'b1000, 0, 0, 0, 30, 1'b0);

        // Reset asserted in cycle 10 of a 4-slot load.
        @(posedge clk); #1;
        c0 = cyc;
        start_load = 1'b1;
        set_inputs(4'b1111, 3, 7, 16, 31);
        gen(1'b0, 4'b1111, 3, 7, 16, 31, c0, c0 + 10);
        @(posedge clk); #1;
        start_load = 1'b0;
        repeat (9) @(posedge clk);
        #1;
        rst_b = 1'b0;
        #1;
        check_all_zero("abort_outputs");
        repeat (2) @(posedge clk);
        #1;
        check_all_zero("abort_held");
        rst_b = 1'b1;
        check_drained("abort_prefix");

        run_seq("load_after_rst", 1'b1, 1'b0, 4'b0101, 5, 6, 8, 9, 1'b0);
        run_seq("save_two",       1'b0, 1'b1, 4'b0011, 2, 29, 0, 0, 1'b0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
